// File: rtl/load_store_unit32.sv
// RV32I load/store unit in front of a word-wide, single-write-enable data memory.
// Optional build macro: LSU_MISALIGN_CHECK_EN (fault on misaligned H/HU/W accesses).
module load_store_unit32 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_fault,
  output logic [N-1:0] mem_addr,
  output logic         mem_write_enable,
  output logic [N-1:0] mem_write_data,
  input  logic [N-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

  state_t       state_q;
  logic         we_q;
  logic [2:0]   funct3_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] merged_q;
  logic         req_ready_q;
  logic         resp_valid_q;
  logic [N-1:0] resp_rdata_q;
  logic         resp_fault_q;

  logic         illegal_d;
  logic         misalign_d;
  logic         fault_d;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [N-1:0] load_fmt_d;
  logic [N-1:0] merged_d;
  logic         is_sw;

  // Stores only have B/H/W encodings; loads additionally allow BU/HU.
  always_comb begin
    illegal_d = 1'b0;
    if (req_funct3 == 3'b011)
      illegal_d = 1'b1;
    else if (req_we)
      illegal_d = req_funct3[2];
    else
      illegal_d = (req_funct3[2:1] == 2'b11);
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign_d = 1'b0;
    if (req_funct3[1:0] == 2'b01)
      misalign_d = req_addr[0];
    else if (req_funct3[1:0] == 2'b10)
      misalign_d = (req_addr[1:0] != 2'b00);
  end
`else
  assign misalign_d = 1'b0;
`endif

  assign fault_d = illegal_d | misalign_d;

  assign byte_sel = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
  assign is_sw    = (funct3_q == 3'b010);

  always_comb begin
    load_fmt_d = '0;
    case (funct3_q)
      3'b000:  load_fmt_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt_d = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_fmt_d = mem_read_data;
      3'b100:  load_fmt_d = {24'd0, byte_sel};
      3'b101:  load_fmt_d = {16'd0, half_sel};
      default: load_fmt_d = '0;
    endcase
  end

  // Sub-word store: keep the untouched lanes of the current word.
  always_comb begin
    merged_d = mem_read_data;
    if (funct3_q[1:0] == 2'b00)
      merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (addr_q[1])
      merged_d[31:16] = wdata_q[15:0];
    else
      merged_d[15:0] = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      merged_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            funct3_q     <= req_funct3;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_fault_q <= fault_d;
            req_ready_q  <= 1'b0;
            if (fault_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            resp_rdata_q <= load_fmt_d;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (is_sw) begin
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            merged_q <= merged_d;
            state_q  <= MERGE_WR;
          end
        end
        MERGE_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

  // Memory side is decoded from state so the combinational read sees the address in ACCESS.
  assign mem_addr = (state_q == ACCESS || state_q == MERGE_WR) ? {2'b00, addr_q[N-1:2]} : '0;

  always_comb begin
    mem_write_data = '0;
    if (state_q == ACCESS && we_q && is_sw)
      mem_write_data = wdata_q;
    else if (state_q == MERGE_WR)
      mem_write_data = merged_q;
  end

  assign mem_write_enable = !reset &&
                            ((state_q == ACCESS && we_q && is_sw) || state_q == MERGE_WR);

endmodule
